sys_arr_mac_driver: RTL and testbench

//  Initiator side of the systolic-array MAC port. It sequences one MAC through a weight preload and then an

---
 rtl/sys_arr_mac_driver.sv | 173 +++++++++++++++++
 tb/tb_sys_arr_mac_driver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_arr_mac_driver.sv
// Initiator for one systolic-array MAC. It preloads a weight, then streams a programmable number of
// operand/psum pairs. Each out_accumulate is collected into a 2-deep result FIFO with a valid/ready port.
module sys_arr_mac_driver #(
  parameter int DW    = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  output logic             done,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [DW-1:0]    w_data,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [DW-1:0]    x_data,
  input  logic [DW-1:0]    ps_data,
  output logic             mac_start,
  output logic [DW-1:0]    mac_in_value,
  output logic             mac_weight_en,
  output logic             mac_shift,
  output logic [DW-1:0]    mac_in_acc,
  output logic             mac_stall,
  input  logic [DW-1:0]    mac_out_acc,
  input  logic             mac_value_rdy,
  input  logic             mac_wnext_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    res_data,
  output logic             res_last
);

  typedef enum logic [1:0] {IDLE, LOAD_W, WAIT_W, STREAM} state_t;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } res_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len, issued, captured;
  logic             inflight;
  res_t [1:0]       fifo_q;
  logic [1:0]       fifo_cnt;

  logic start_job, start_empty, x_fire, cap, cap_last, pop, fifo_room;
  res_t cap_ent;

  assign busy      = (state != IDLE);
  assign res_valid = (fifo_cnt != 2'd0);
  assign res_data  = fifo_q[0].data;
  assign res_last  = fifo_q[0].last;
  assign pop       = res_valid & res_ready;
  // A full FIFO can still accept when its head leaves in the same cycle.
  assign fifo_room = (fifo_cnt != 2'd2) | pop;
  assign mac_stall = inflight & (fifo_cnt == 2'd2);
  assign cap_last  = (captured == len - LEN_W'(1));
  assign cap_ent   = '{last: cap_last, data: mac_out_acc};

  always_comb begin
    state_nxt     = state;
    w_ready       = 1'b0;
    x_ready       = 1'b0;
    x_fire        = 1'b0;
    cap           = 1'b0;
    start_job     = 1'b0;
    start_empty   = 1'b0;
    mac_start     = 1'b0;
    mac_weight_en = 1'b0;
    mac_shift     = 1'b0;
    mac_in_value  = '0;
    mac_in_acc    = '0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) begin
            start_job = 1'b1;
            state_nxt = LOAD_W;
          end else begin
            start_empty = 1'b1;
          end
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          mac_start     = 1'b1;
          mac_weight_en = 1'b1;
          mac_in_value  = w_data;
          state_nxt     = WAIT_W;
        end
      end
      WAIT_W: begin
        if (mac_wnext_en) state_nxt = STREAM;
      end
      STREAM: begin
        // Issue only when a FIFO slot is free for the op about to go in flight.
        x_ready = ~inflight & mac_value_rdy & (issued < len) & (fifo_cnt < 2'd2);
        x_fire  = x_ready & x_valid;
        if (x_fire) begin
          mac_start    = 1'b1;
          mac_shift    = 1'b1;
          mac_in_value = x_data;
          mac_in_acc   = ps_data;
        end
        cap = inflight & mac_value_rdy & fifo_room;
        if (cap && cap_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      issued   <= '0;
      captured <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= start_empty | (cap & cap_last);
      if (start_job) begin
        len      <= cfg_len;
        issued   <= '0;
        captured <= '0;
        inflight <= 1'b0;
      end
      // x_fire needs !inflight and cap needs inflight, so these never collide.
      if (x_fire) begin
        issued   <= issued + LEN_W'(1);
        inflight <= 1'b1;
      end
      if (cap) begin
        captured <= captured + LEN_W'(1);
        inflight <= 1'b0;
      end
    end
  end

  // Shift-style FIFO: entry 0 is always the head and drives the result port directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
      fifo_q   <= '0;
    end else begin
      case ({cap, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo_q[0] <= cap_ent;
          else                  fifo_q[1] <= cap_ent;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          if (fifo_cnt == 2'd2) fifo_q[0] <= fifo_q[1];
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_q[0] <= cap_ent;
          end else begin
            fifo_q[0] <= fifo_q[1];
            fifo_q[1] <= cap_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_arr_mac_driver.sv
// Randomized bench for sys_arr_mac_driver: a MAC responder drives the MAC side, and a
// spec-level model (queues + counters) predicts every output each cycle.
module tb_sys_arr_mac_driver;
  localparam int DW = 16;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic cfg_start = 0, w_valid = 0, x_valid = 0, res_ready = 0;
  logic mac_value_rdy = 0, mac_wnext_en = 0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [DW-1:0] w_data = '0, x_data = '0, ps_data = '0, mac_out_acc = '0;
  logic busy, done, w_ready, x_ready, mac_start, mac_weight_en, mac_shift, mac_stall;
  logic res_valid, res_last;
  logic [DW-1:0] mac_in_value, mac_in_acc, res_data;

  sys_arr_mac_driver #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .ps_data(ps_data),
    .mac_start(mac_start), .mac_in_value(mac_in_value), .mac_weight_en(mac_weight_en),
    .mac_shift(mac_shift), .mac_in_acc(mac_in_acc), .mac_stall(mac_stall),
    .mac_out_acc(mac_out_acc), .mac_value_rdy(mac_value_rdy), .mac_wnext_en(mac_wnext_en),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );

  typedef struct packed { logic last; logic [DW-1:0] d; } ent_t;

  int tests = 0, fails = 0, cyc = 0;
  // model of the driver
  int m_phase = 0, m_len = 0, m_issued = 0, m_captured = 0;
  bit m_inflight = 0, m_done = 0;
  logic [DW-1:0] m_w = '0;
  ent_t m_q[$], sb[$], got[$];
  // MAC responder
  bit op_v = 0, wl_v = 0;
  int op_cyc = 0, wl_cyc = 0;
  logic [DW-1:0] mac_res = '0, mac_w = '0;
  // stimulus knobs
  int lat = 1, wdelay = 2, p_wv = 100, p_xv = 100, p_rr = 100, p_drop = 0;
  bit xtoggle = 0, use_xs = 0, ps_zero = 0, rst_req = 1, pend_start = 0;
  int pend_len = 0;
  logic [DW-1:0] job_w = '0;
  logic [DW-1:0] xs[$];
  int n_done = 0, n_wst = 0, n_xst = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit pct(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic step();
    bit wf, xf, cap, pop, e_xr, e_rv, bm, rst_now;
    logic [DW-1:0] e_iv, e_ia;
    ent_t e;
    @(negedge clk);
    rst_now = rst_req;
    rst = rst_req;
    cfg_start = pend_start;
    cfg_len = LEN_W'(pend_len);
    pend_start = 0;
    w_valid = pct(p_wv);
    w_data = job_w;
    x_valid = xtoggle ? cyc[0] : pct(p_xv);
    x_data = (use_xs && m_issued < xs.size()) ? xs[m_issued] : DW'($urandom);
    ps_data = ps_zero ? '0 : DW'($urandom);
    res_ready = pct(p_rr);
    mac_wnext_en = wl_v && (cyc - wl_cyc >= wdelay);
    bm = op_v && (cyc - op_cyc < lat);
    mac_value_rdy = !bm && !pct(p_drop);
    mac_out_acc = bm ? DW'($urandom) : mac_res;
    #1;
    if (rst_now) begin
      m_phase = 0; m_len = 0; m_issued = 0; m_captured = 0;
      m_inflight = 0; m_done = 0;
      m_q.delete(); sb.delete();
    end else begin
      e_rv = m_q.size() > 0;
      pop = e_rv && res_ready;
      wf = (m_phase == 1) && w_valid;
      e_xr = (m_phase == 3) && !m_inflight && mac_value_rdy && (m_issued < m_len) && (m_q.size() < 2);
      xf = e_xr && x_valid;
      cap = (m_phase == 3) && m_inflight && mac_value_rdy;
      e_iv = wf ? w_data : (xf ? x_data : '0);
      e_ia = xf ? ps_data : '0;
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_done);
      chk("w_ready", w_ready, m_phase == 1);
      chk("x_ready", x_ready, e_xr);
      chk("mac_start", mac_start, wf || xf);
      chk("mac_weight_en", mac_weight_en, wf);
      chk("mac_shift", mac_shift, xf);
      chk("mac_in_value", mac_in_value, e_iv);
      chk("mac_in_acc", mac_in_acc, e_ia);
      chk("mac_stall", mac_stall, m_inflight && m_q.size() == 2);
      chk("res_valid", res_valid, e_rv);
      if (e_rv) begin
        chk("res_data", res_data, m_q[0].d);
        chk("res_last", res_last, m_q[0].last);
      end
      if (pop) begin
        chk("sb_avail", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_data", res_data, e.d);
          chk("sb_last", res_last, e.last);
        end
        e.d = res_data; e.last = res_last;
        got.push_back(e);
        void'(m_q.pop_front());
      end
      if (done) n_done++;
      if (mac_start && mac_weight_en) n_wst++;
      if (mac_start && mac_shift) n_xst++;
      m_done = 0;
      case (m_phase)
        0: if (cfg_start) begin
             if (cfg_len != 0) begin
               m_phase = 1; m_len = cfg_len; m_issued = 0; m_captured = 0; m_inflight = 0;
             end else m_done = 1;
           end
        1: if (wf) begin m_w = w_data; m_phase = 2; end
        2: if (mac_wnext_en) m_phase = 3;
        default: begin
          if (xf) begin
            e.d = DW'(ps_data + m_w * x_data); e.last = (m_issued == m_len - 1);
            sb.push_back(e);
            m_issued++; m_inflight = 1;
          end else if (cap) begin
            e.d = mac_out_acc; e.last = (m_captured == m_len - 1);
            m_q.push_back(e);
            if (e.last) begin m_phase = 0; m_done = 1; end
            m_captured++; m_inflight = 0;
          end
        end
      endcase
    end
    if (mac_start && mac_weight_en) begin mac_w = mac_in_value; wl_v = 1; wl_cyc = cyc; end
    if (mac_start && mac_shift) begin
      mac_res = DW'(mac_in_acc + mac_w * mac_in_value); op_v = 1; op_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic start_job(input int len);
    got.delete();
    pend_start = 1; pend_len = len;
    step();
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((m_phase != 0 || m_q.size() != 0) && n < budget) begin step(); n++; end
    chk("job_timeout", n >= budget, 0);
    step();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {busy, done, w_ready, x_ready, mac_start, mac_weight_en, mac_shift,
                       mac_stall, res_valid, res_last}, 0);
    chk({nm, "_val"}, mac_in_value, 0);
    chk({nm, "_acc"}, mac_in_acc, 0);
    chk({nm, "_res"}, res_data, 0);
  endtask

  task automatic chk_got(input string nm, input int a, input int b, input int c);
    int ex[3];
    ex[0] = a; ex[1] = b; ex[2] = c;
    chk({nm, "_n"}, got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      chk({nm, "_d"}, got[i].d, ex[i]);
      chk({nm, "_l"}, got[i].last, i == 2);
    end
  endtask

  initial begin
    int d0, w0, x0, b, ln;
    step(); step();
    rst_req = 0;
    step();
    chk_zero("reset");

    // T1: empty job
    d0 = n_done; w0 = n_wst; x0 = n_xst;
    start_job(0);
    step();
    chk("t1_done", done, 1);
    step();
    chk("t1_done_once", n_done - d0, 1);
    chk("t1_no_start", (n_wst - w0) + (n_xst - x0), 0);
    chk("t1_wready", w_ready, 0);

    // T2: w=3, x={1,2,4}, ps=0
    use_xs = 1; ps_zero = 1; job_w = 3; xs = '{16'd1, 16'd2, 16'd4};
    d0 = n_done;
    start_job(3);
    run_idle(300);
    chk_got("t2", 3, 6, 12);
    chk("t2_done", n_done - d0, 1);

    // T3: results back up in the FIFO, then drain
    p_rr = 0; x0 = n_xst;
    start_job(3);
    repeat (30) step();
    chk("t3_issued", n_xst - x0, 2);
    chk("t3_xready", x_ready, 0);
    chk("t3_head", res_data, 3);
    chk("t3_valid", res_valid, 1);
    p_rr = 100;
    run_idle(300);
    chk_got("t3", 3, 6, 12);
    use_xs = 0; ps_zero = 0;

    // T4: toggling x_valid, slow MAC
    xtoggle = 1; lat = 4; job_w = DW'($urandom); x0 = n_xst; d0 = n_done;
    start_job(5);
    run_idle(500);
    chk("t4_issues", n_xst - x0, 5);
    chk("t4_done", n_done - d0, 1);
    xtoggle = 0;

    // T5: reset mid-stream, then a fresh len=1 job
    lat = 2; d0 = n_done;
    start_job(4);
    b = 0;
    while (m_captured < 1 && b < 300) begin step(); b++; end
    chk("t5_reach", b >= 300, 0);
    rst_req = 1; step(); rst_req = 0;
    step();
    chk_zero("t5_rst");
    repeat (5) step();
    chk("t5_no_done", n_done - d0, 0);
    start_job(1);
    run_idle(300);
    chk("t5_new_n", got.size(), 1);
    chk("t5_new_done", n_done - d0, 1);

    // T6: cfg_start during STREAM is ignored
    x0 = n_xst;
    start_job(3);
    b = 0;
    while (m_phase != 3 && b < 100) begin step(); b++; end
    pend_start = 1; pend_len = 5;
    run_idle(500);
    chk("t6_issues", n_xst - x0, 3);
    chk("t6_n", got.size(), 3);

    // random jobs
    for (int j = 0; j < 40; j++) begin
      ln = $urandom_range(0, 9);
      lat = $urandom_range(1, 4); wdelay = $urandom_range(1, 4);
      p_wv = $urandom_range(30, 100); p_xv = $urandom_range(30, 100);
      p_rr = $urandom_range(20, 100); p_drop = $urandom_range(0, 30);
      job_w = DW'($urandom);
      start_job(ln);
      run_idle(2000);
      chk("rnd_count", got.size(), ln);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end
endmodule
